perceptron_sample_sequencer: RTL and testbench

//  Training-sample feeder directly upstream of perceptron. Stores up to DEPTH labelled 5x5-class patterns
//  ({label, 24-bit pattern}), replays them in order to perceptron over repeated epochs via en/ready handshake,

---
 rtl/perceptron_sample_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_perceptron_sample_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_sample_sequencer.sv
// -----------------------------------------------------------------------------
// perceptron_sample_sequencer
//
// Training-sample feeder that sits directly upstream of the perceptron. It
// holds up to DEPTH labelled patterns ({label, pattern[23:0]}), replays them
// in address order over repeated epochs, and scores each perceptron answer
// against the stored label. A run ends on the first epoch with no errors
// (converged) or after MAX_EPOCHS epochs.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   sample memory write strobe (ignored while busy)
//   wr_addr      in   sample memory write address
//   wr_data      in   {label, pattern[23:0]}
//   num_samples  in   samples per epoch, captured at start, clamped to DEPTH
//   start        in   single-cycle run request (ignored while busy)
//   perc_in      out  sample presented to the perceptron
//   perc_en      out  perceptron enable
//   perc_ready   in   perceptron result valid
//   perc_out     in   perceptron result; bit 0 is the predicted class
//   busy         out  run in progress
//   done         out  single-cycle pulse at end of run
//   converged    out  last run ended on an error-free epoch
//   epoch_cnt    out  completed epochs of the current/last run
//   err_cnt      out  mismatches in the current (or last) epoch
//
// States
//   IDLE      | waiting for start, sample memory writable
//   LOAD      | fetch mem[idx] into perc_in
//   PRESENT   | perc_en high, wait for a qualified perc_ready, score result
//   GAP       | perc_en low, wait for perc_ready to drop, advance idx
//   EPOCH_END | count the epoch, decide converge / give up / next epoch
//   FINISH    | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module perceptron_sample_sequencer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int MAX_EPOCHS = 16,
    parameter int EPOCH_W    = 5,
    parameter int MIN_HOLD   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [24:0]        wr_data,
    input  logic [ADDR_W:0]    num_samples,
    input  logic               start,
    output logic [24:0]        perc_in,
    output logic               perc_en,
    input  logic               perc_ready,
    input  logic [1:0]         perc_out,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [ADDR_W:0]    err_cnt
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);

    localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_C     = HOLD_W'(MIN_HOLD);
    localparam logic [EPOCH_W-1:0] MAX_EPOCH_C = EPOCH_W'(MAX_EPOCHS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_GAP,
        S_EPOCH_END,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [24:0]        mem [DEPTH];
    logic [CNT_W-1:0]   n_lat;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_inc;
    logic [CNT_W-1:0]   num_clamped;
    logic [HOLD_W-1:0]  hold;
    logic [EPOCH_W-1:0] epoch_inc;

    logic accept;
    logic mismatch;
    logic last_sample;
    logic epoch_clean;
    logic epoch_limit;

    // Only the predicted class (bit 0) matters to this block.
    logic perc_out_unused;
    assign perc_out_unused = perc_out[1];

    // -------------------------------------------------------------------------
    // Sample memory: no reset, contents survive rst_n.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    always_comb begin
        num_clamped = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
        idx_inc     = idx + CNT_W'(1);
        last_sample = (idx_inc == n_lat);
        epoch_inc   = epoch_cnt + EPOCH_W'(1);
        epoch_clean = (err_cnt == '0);
        epoch_limit = (epoch_inc == MAX_EPOCH_C);
        mismatch    = (perc_out[0] != perc_in[24]);
        // hold saturates at MIN_HOLD, so a ready that is already high on
        // PRESENT entry is only taken once the minimum hold has elapsed.
        accept      = (state == S_PRESENT) && perc_ready && (hold >= HOLD_C);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        perc_en   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_clamped == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                perc_en = 1'b1;
                if (accept) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (!perc_ready) begin
                    state_nxt = last_sample ? S_EPOCH_END : S_LOAD;
                end
            end
            S_EPOCH_END: begin
                state_nxt = (epoch_clean || epoch_limit) ? S_FINISH : S_LOAD;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat     <= '0;
            idx       <= '0;
            hold      <= '0;
            perc_in   <= '0;
            err_cnt   <= '0;
            epoch_cnt <= '0;
            converged <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat     <= num_clamped;
                        idx       <= '0;
                        epoch_cnt <= '0;
                        err_cnt   <= '0;
                        // An empty run is trivially converged.
                        converged <= (num_clamped == '0);
                    end
                end
                S_LOAD: begin
                    perc_in <= mem[idx[ADDR_W-1:0]];
                    hold    <= '0;
                end
                S_PRESENT: begin
                    if (hold < HOLD_C) begin
                        hold <= hold + HOLD_W'(1);
                    end
                    if (accept && mismatch && !(&err_cnt)) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (!perc_ready) begin
                        idx <= idx_inc;
                    end
                end
                S_EPOCH_END: begin
                    if (!(&epoch_cnt)) begin
                        epoch_cnt <= epoch_inc;
                    end
                    if (epoch_clean) begin
                        converged <= 1'b1;
                    end else if (!epoch_limit) begin
                        idx     <= '0;
                        err_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_sample_sequencer.sv
module tb_perceptron_sample_sequencer;

    localparam int DEPTH      = 8;
    localparam int MAX_EPOCHS = 16;
    localparam int MIN_HOLD   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [24:0] wr_data;
    logic [3:0]  num_samples;
    logic        start;
    logic [24:0] perc_in;
    logic        perc_en;
    logic        perc_ready;
    logic [1:0]  perc_out;
    logic        busy;
    logic        done;
    logic        converged;
    logic [4:0]  epoch_cnt;
    logic [3:0]  err_cnt;

    perceptron_sample_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .num_samples (num_samples),
        .start       (start),
        .perc_in     (perc_in),
        .perc_en     (perc_en),
        .perc_ready  (perc_ready),
        .perc_out    (perc_out),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .epoch_cnt   (epoch_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference memory contents and the answer plan: wrong_tab[e][i] = 1 means
    // the emulated perceptron answers sample i of epoch e incorrectly.
    logic [24:0] mem_m [DEPTH];
    bit          wrong_tab [MAX_EPOCHS][DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int errs_before(input int e, input int i);
        int c = 0;
        for (int k = 0; k < i; k++) c += int'(wrong_tab[e][k]);
        return c;
    endfunction

    task automatic plan_clear();
        for (int e = 0; e < MAX_EPOCHS; e++)
            for (int i = 0; i < DEPTH; i++) wrong_tab[e][i] = 1'b0;
    endtask

    task automatic plan_random();
        for (int e = 0; e < MAX_EPOCHS; e++)
            for (int i = 0; i < DEPTH; i++) wrong_tab[e][i] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic write_mem(input int a, input logic [24:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    // Start a run, act as the perceptron until done, and check against the
    // expected outcome derived from the answer plan.
    task automatic run_check(input int num, input bit noisy);
        int  n, exp_epochs, exp_err, ec, cycles, p, e, i, dly, en_len, gap_left;
        bit  exp_conv, found, seen_done, en_prev, pred;
        logic [24:0] cur_in;

        n = (num > DEPTH) ? DEPTH : num;
        exp_epochs = 0;
        exp_err    = 0;
        exp_conv   = 1'b1;
        if (n != 0) begin
            found      = 1'b0;
            exp_epochs = MAX_EPOCHS;
            exp_conv   = 1'b0;
            for (int k = 0; k < MAX_EPOCHS; k++) begin
                ec = errs_before(k, n);
                if (!found && ec == 0) begin
                    found      = 1'b1;
                    exp_epochs = k + 1;
                    exp_conv   = 1'b1;
                    exp_err    = 0;
                end
                if (!found) exp_err = ec;
            end
        end

        @(negedge clk);
        num_samples = 4'(num);
        start       = 1'b1;
        perc_ready  = 1'b0;
        @(negedge clk);

        cycles = 0; p = 0; en_prev = 1'b0; en_len = 0; dly = 0; gap_left = 0;
        seen_done = 1'b0; pred = 1'b0; cur_in = '0;
        while (!seen_done && cycles < 6000) begin
            start = 1'b0;
            wr_en = 1'b0;
            if (!perc_ready) perc_out = 2'($urandom_range(0, 3));
            if (perc_en) begin
                if (!en_prev) begin
                    e = p / n;
                    i = p % n;
                    if (e > MAX_EPOCHS - 1) e = MAX_EPOCHS - 1;
                    chk("present_data", perc_in, mem_m[i]);
                    chk("epoch_at_present", 32'(epoch_cnt), e);
                    chk("err_at_present", 32'(err_cnt), errs_before(e, i));
                    pred   = mem_m[i][24] ^ wrong_tab[e][i];
                    cur_in = mem_m[i];
                    dly    = $urandom_range(0, 10);
                    en_len = 0;
                    p++;
                end else begin
                    chk("present_stable", perc_in, cur_in);
                end
                if (en_len >= dly) begin
                    perc_ready = 1'b1;
                    perc_out   = {1'($urandom_range(0, 1)), pred};
                end
                en_len++;
            end else begin
                if (en_prev) begin
                    chk("present_len", en_len, ((dly > MIN_HOLD) ? dly : MIN_HOLD) + 1);
                    gap_left = $urandom_range(0, 3);
                end
                if (perc_ready) begin
                    if (gap_left == 0) perc_ready = 1'b0;
                    else gap_left--;
                end
            end
            if (noisy && busy && $urandom_range(0, 7) == 0) begin
                wr_en   = 1'b1;
                wr_addr = 3'($urandom_range(0, 7));
                wr_data = 25'($urandom);
            end
            if (noisy && busy && $urandom_range(0, 15) == 0) begin
                start       = 1'b1;
                num_samples = 4'($urandom_range(0, 15));
            end
            en_prev = perc_en;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                cycles++;
                @(negedge clk);
            end
        end

        chk("done_seen", 32'(seen_done), 1);
        if (n == 0) chk("n0_done_latency", cycles, 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_perc_en", 32'(perc_en), 0);
        chk("converged", 32'(converged), 32'(exp_conv));
        chk("epoch_cnt", 32'(epoch_cnt), exp_epochs);
        chk("err_cnt", 32'(err_cnt), exp_err);
        chk("presentations", p, n * exp_epochs);

        // start while FINISH is active must not launch a new run
        wr_en       = 1'b0;
        perc_ready  = 1'b0;
        start       = 1'b1;
        num_samples = 4'd2;
        @(negedge clk);
        start = 1'b0;
        chk("after_done_busy", 32'(busy), 0);
        chk("after_done_done", 32'(done), 0);
        chk("hold_converged", 32'(converged), 32'(exp_conv));
        chk("hold_epoch_cnt", 32'(epoch_cnt), exp_epochs);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_samples = '0; start = 1'b0; perc_ready = 1'b0; perc_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_perc_en", 32'(perc_en), 0);
        chk("rst_perc_in", perc_in, 0);
        chk("rst_epoch_cnt", 32'(epoch_cnt), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_converged", 32'(converged), 0);
        rst_n = 1'b1;

        write_mem(0, 25'h0_45_45_44);
        write_mem(1, 25'h1_15_11_51);
        for (int a = 2; a < DEPTH; a++) write_mem(a, 25'($urandom));

        // always correct
        plan_clear();
        run_check(2, 1'b0);
        // wrong on the cross during the first epoch only
        plan_clear();
        wrong_tab[0][1] = 1'b1;
        run_check(2, 1'b0);
        // perceptron always answers class 0
        for (int e = 0; e < MAX_EPOCHS; e++)
            for (int i = 0; i < DEPTH; i++) wrong_tab[e][i] = mem_m[i][24];
        run_check(2, 1'b0);
        // empty run
        run_check(0, 1'b0);
        // oversize request clamps; writes and starts while busy are ignored
        plan_random();
        run_check(12, 1'b1);
        plan_clear();
        run_check(15, 1'b0);

        for (int r = 0; r < 4; r++) begin
            write_mem($urandom_range(0, 7), 25'($urandom));
            plan_random();
            run_check($urandom_range(1, 15), 1'b1);
        end

        // reset in the middle of a presentation
        @(negedge clk);
        num_samples = 4'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!perc_en && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("t1_reached_present", 32'(perc_en), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_perc_en", 32'(perc_en), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_done", 32'(done), 0);
        chk("t1_converged", 32'(converged), 0);
        chk("t1_epoch_cnt", 32'(epoch_cnt), 0);
        chk("t1_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // memory survives reset
        plan_clear();
        run_check(3, 1'b0);

        // perc_ready stuck high: one MIN_HOLD+1 presentation, then GAP forever
        @(negedge clk);
        perc_ready  = 1'b1;
        perc_out    = 2'b00;
        num_samples = 4'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!perc_en && k < 20) begin
            k++;
            @(negedge clk);
        end
        k = 0;
        while (perc_en && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("t5_present_len", k, MIN_HOLD + 1);
        repeat (30) @(negedge clk);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_perc_en", 32'(perc_en), 0);
        chk("t5_done", 32'(done), 0);
        rst_n      = 1'b0;
        perc_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rst_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
